// File: rtl/pe_mux_pipe.sv
// Multi-lane raw/activated select with per-lane mask, registered into a
// 2-entry valid/ready output buffer and a wrapping delivered-beat counter.
module pe_mux_pipe #(
  parameter int W     = 24,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [LANES-1:0]     cfg_sel,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_y,
  output logic [LANES-1:0]     sel_q,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int DW = LANES * W;

  logic [LANES-1:0] sel_d;
  logic [DW-1:0]    head_q, head_d;
  logic [DW-1:0]    tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]    beat;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_y     = head_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    beat = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      beat[l*W +: W] = sel_q[l] ? in_b[l*W +: W] : in_a[l*W +: W];
    end
  end

  // A flushed edge never accepts a beat, but a pop on that edge still counts.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    sel_d      = cfg_we ? cfg_sel : sel_q;
    beat_cnt_d = beat_cnt_q + CNT_W'(pop);
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = beat;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              tail_d  = beat;
              count_d = 2'd2;
            end
            2'b01:   count_d = 2'd0;
            2'b11:   head_d  = beat;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      sel_q      <= sel_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_pe_mux_pipe.sv
// Directed bench for pe_mux_pipe with W=24, LANES=4 and a 3-bit beat counter
// so that counter wrap is reached within a short stream.
module tb_pe_mux_pipe;

  localparam int W = 24;
  localparam int LANES = 4;
  localparam int CNT_W = 3;
  localparam int DW = W * LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [LANES-1:0] cfg_sel;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_y;
  logic [LANES-1:0] sel_q;
  logic [CNT_W-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  pe_mux_pipe #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .sel_q(sel_q), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int v3, input int v2, input int v1, input int v0);
    logic [DW-1:0] r;
    r[23:0]  = v0[23:0];
    r[47:24] = v1[23:0];
    r[71:48] = v2[23:0];
    r[95:72] = v3[23:0];
    return r;
  endfunction

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_sel = '0; flush = 0; in_valid = 0;
    out_ready = 0; in_a = '0; in_b = '0;
    @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_y", out_y, '0);
    chk("rst_sel_q", DW'(sel_q), DW'(0));
    chk("rst_beat_cnt", DW'(beat_cnt), DW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", DW'(in_ready), DW'(1));

    // 1: mixed lane mask
    cfg_we = 1; cfg_sel = 4'b0101;
    @(negedge clk);
    chk("t1_sel_q", DW'(sel_q), DW'(4'b0101));
    cfg_we = 0; in_valid = 1;
    in_a = pk(-1, 2, -3, 4); in_b = pk(10, 20, 30, 40);
    @(negedge clk);
    chk("t1_out_valid", DW'(out_valid), DW'(1));
    chk("t1_out_y", out_y, pk(-1, 20, -3, 40));
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("t1_drained", DW'(out_valid), DW'(0));
    chk("t1_beat_cnt", DW'(beat_cnt), DW'(1));

    // 2: mask change on the accepting edge uses the old mask
    cfg_we = 1; cfg_sel = 4'b0000;
    @(negedge clk);
    cfg_sel = 4'hF; in_valid = 1;
    in_a = pk(7, -8, 9, -10); in_b = pk(70, -80, 90, -100);
    @(negedge clk);
    chk("t2_sel_q", DW'(sel_q), DW'(4'hF));
    chk("t2_old_mask", out_y, pk(7, -8, 9, -10));
    cfg_we = 0;
    in_a = pk(1, 1, 1, 1); in_b = pk(-5, 6, -7, 8);
    @(negedge clk);
    chk("t2_new_mask", out_y, pk(-5, 6, -7, 8));
    chk("t2_beat_cnt", DW'(beat_cnt), DW'(2));
    in_valid = 0;
    @(negedge clk);
    chk("t2_drained", DW'(out_valid), DW'(0));
    chk("t2_beat_cnt2", DW'(beat_cnt), DW'(3));

    // 3: backpressure, full buffer, in-order release
    out_ready = 0; in_valid = 1; in_a = '0;
    in_b = pk(-1, 1, -1, 1);
    @(negedge clk);
    chk("t3_ready_one", DW'(in_ready), DW'(1));
    in_b = pk(-2, 2, -2, 2);
    @(negedge clk);
    chk("t3_ready_full", DW'(in_ready), DW'(0));
    chk("t3_head1", out_y, pk(-1, 1, -1, 1));
    in_b = pk(-3, 3, -3, 3);
    @(negedge clk);
    chk("t3_still_full", DW'(in_ready), DW'(0));
    chk("t3_hold", out_y, pk(-1, 1, -1, 1));
    chk("t3_hold_valid", DW'(out_valid), DW'(1));
    out_ready = 1;
    @(negedge clk);
    chk("t3_beat2", out_y, pk(-2, 2, -2, 2));
    chk("t3_ready_again", DW'(in_ready), DW'(1));
    @(negedge clk);
    chk("t3_beat3", out_y, pk(-3, 3, -3, 3));
    in_valid = 0;
    @(negedge clk);
    chk("t3_drained", DW'(out_valid), DW'(0));
    chk("t3_beat_cnt", DW'(beat_cnt), DW'(6));

    // 4: full-rate stream, counter wraps 7 -> 0 at the third beat
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_b = pk(i, -i, 100 + i, -100 - i);
      @(negedge clk);
      chk("t4_valid", DW'(out_valid), DW'(1));
      chk("t4_ready", DW'(in_ready), DW'(1));
      chk("t4_y", out_y, pk(i, -i, 100 + i, -100 - i));
      chk("t4_cnt", DW'(beat_cnt), DW'((6 + i) % 8));
    end
    in_valid = 0;
    @(negedge clk);
    chk("t4_drained", DW'(out_valid), DW'(0));
    chk("t4_beat_cnt", DW'(beat_cnt), DW'(6));

    // 5: flush a full buffer while a beat is offered
    out_ready = 0; in_valid = 1;
    in_b = pk(11, 11, 11, 11);
    @(negedge clk);
    in_b = pk(22, 22, 22, 22);
    @(negedge clk);
    chk("t5_full", DW'(in_ready), DW'(0));
    flush = 1; in_b = pk(33, 33, 33, 33);
    @(negedge clk);
    chk("t5_flushed", DW'(out_valid), DW'(0));
    chk("t5_sel_kept", DW'(sel_q), DW'(4'hF));
    chk("t5_cnt_kept", DW'(beat_cnt), DW'(6));
    flush = 0; in_b = pk(44, -44, 44, -44);
    @(negedge clk);
    chk("t5_after_flush", out_y, pk(44, -44, 44, -44));
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("t5_single", DW'(out_valid), DW'(0));
    chk("t5_beat_cnt", DW'(beat_cnt), DW'(7));

    // 6: asynchronous reset with a full buffer
    out_ready = 0; in_valid = 1;
    in_b = pk(5, 5, 5, 5);
    @(negedge clk);
    in_b = pk(6, 6, 6, 6);
    @(negedge clk);
    chk("t6_full", DW'(in_ready), DW'(0));
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_out_valid", DW'(out_valid), DW'(0));
    chk("t6_out_y", out_y, '0);
    chk("t6_sel_q", DW'(sel_q), DW'(0));
    chk("t6_beat_cnt", DW'(beat_cnt), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
